xcorr_seq_ctrl: RTL
===================

// Module: xcorr_seq_ctrl
// PURPOSE
//  Sequences the cross-correlation engine inside the mic subsystem. Arms the engine, streams one
//  frame of N_SAMP paired mic samples into it, collects the 2*MAX_LAG+1 per-lag results, runs a
//  peak search and publishes the winning lag as lag_diff. Sits between the sign-extension stage
//  and the xcorr core on the 60 MHz domain; enabled by the debounced XC_EN level.
// PARAMETERS
//  W        16   sample width (signed)
//  N_SAMP   512  samples per correlation frame
//  MAX_LAG  31   lags evaluated: -MAX_LAG..+MAX_LAG, one result each
//  ACC_W    32   xcorr result width (signed)
//  LAG_W    6    lag_diff width (signed); must hold +/-MAX_LAG
//  TIMEOUT  4096 WAIT-state watchdog cycles (used only when XCORR_SEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1      60 MHz system clock
//  rst          in   1      asynchronous reset, active-high
//  en           in   1      level enable (debounced XC_EN)
//  smp_valid    in   1      new sample pair strobe
//  smp_x/smp_y  in   W      signed mic samples
//  xc_start     out  1      1-cycle arm pulse to xcorr core
//  xc_x/xc_y    out  W      samples to core, registered
//  xc_vld       out  1      qualifies xc_x/xc_y
//  xc_complete  in   1      core: one lag result valid
//  xc_result    in   ACC_W  core: signed correlation value
//  lag_valid    out  1      1-cycle pulse, lag_diff updated
//  lag_diff     out  LAG_W  signed winning lag
//  busy         out  1      high in any state but IDLE
//  ovr          out  1      sticky: sample arrived outside STREAM while en high
//  tmo          out  1      sticky: watchdog fired (0 when macro absent)
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; lag_diff 0; counters/peak cleared.
//  - FSM: IDLE -(en)-> ARM -> STREAM -(N_SAMP fwd)-> WAIT -(last result)-> DONE -> ARM if en else IDLE.
//  - ARM: xc_start=1 for exactly one cycle; sample cnt, lag idx (=-MAX_LAG), peak cleared.
//  - STREAM: each smp_valid registers smp_x/y to xc_x/y with xc_vld=1 next cycle (latency 1).
//    xc_x/y forced 0 when not forwarding. Sample N_SAMP-1 forwarded -> WAIT next cycle.
//  - WAIT: each xc_complete: if first result or xc_result > peak (signed, strict), store peak and
//    lag idx; lag idx++. Ties keep the earliest (most negative) lag. On result 2*MAX_LAG+1 -> DONE.
//  - DONE: lag_diff <= stored lag idx, lag_valid=1 one cycle; lag_diff held until next DONE.
//  - smp_valid in IDLE/ARM/WAIT/DONE with en=1: sample dropped, ovr set. ovr/tmo clear on en=0.
//  - en falls in ARM/STREAM/WAIT: abort to IDLE next cycle, no lag_valid, lag_diff unchanged;
//    in DONE the pulse still completes. xc_complete outside WAIT ignored.
//  - Async rst mid-frame: immediate return to reset values; no partial output.
// CONFIGURATION
//  XCORR_SEQ_TIMEOUT_EN defined: WAIT counter reloads on each xc_complete; reaching TIMEOUT with
//  no result -> tmo set, go to IDLE (re-arms next cycle if en). Same-cycle xc_complete wins over
//  expiry. Undefined: no watchdog, WAIT waits indefinitely, tmo tied 0.
// STRUCTURE
//  - Package xcorr_pkg: state enum (IDLE,ARM,STREAM,WAIT,DONE), N_LAGS=2*MAX_LAG+1 constant,
//    clog2-based counter width helpers; shared with xcorr core.
//  - Sub-module xcorr_peak_track: clear/update/tie rule for peak value + lag index.
// TESTING
//  - rst pulse with en=1 -> all outputs 0, busy 0 during rst, xc_start one cycle after release.
//  - en=1, y = x delayed 5 samples, 512 ramps -> one lag_valid, lag_diff = +5 (signed).
//  - Core returns all 63 results = 100 -> lag_diff = -31 (earliest tie).
//  - Results peak -7 at idx 0 then all lower -> lag_diff = -31; negative peak handled signed.
//  - en dropped after 200 samples -> IDLE next cycle, no lag_valid, lag_diff keeps prior value.
//  - smp_valid during WAIT -> ovr=1, held; en=0 -> ovr=0. TIMEOUT_EN: stall core -> tmo=1
//    after 4096 cycles, xc_start re-issued.

Source files
------------

// File: rtl/xcorr_pkg.sv
// Shared definitions for the cross-correlation sequencer and core:
// sequencer state encoding, lag-count constant and counter width helpers.
package xcorr_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    STREAM = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } xc_state_e;

  localparam int unsigned MAX_LAG_DEF = 31;
  localparam int unsigned N_LAGS      = 2 * MAX_LAG_DEF + 1;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Number of per-lag results produced for a given maximum lag.
  function automatic int unsigned n_lags(input int unsigned max_lag);
    return 2 * max_lag + 1;
  endfunction

endpackage

// File: rtl/xcorr_peak_track.sv
// Running maximum over the per-lag correlation results of one frame.
// The first result after a clear is always taken; later results replace the
// stored peak only when strictly greater (signed), so ties keep the earliest,
// i.e. most negative, lag.
module xcorr_peak_track #(
  parameter int ACC_W = 32,
  parameter int LAG_W = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    upd,
  input  logic signed [ACC_W-1:0] val,
  input  logic signed [LAG_W-1:0] idx,
  output logic signed [LAG_W-1:0] best_idx
);

  logic                    have_q, have_d;
  logic signed [ACC_W-1:0] peak_q, peak_d;
  logic signed [LAG_W-1:0] idx_q,  idx_d;

  // Clear at the start of a frame, otherwise take a new strictly-higher peak.
  always_comb begin
    have_d = have_q;
    peak_d = peak_q;
    idx_d  = idx_q;
    if (clr) begin
      have_d = 1'b0;
      peak_d = '0;
      idx_d  = '0;
    end else if (upd && (!have_q || (val > peak_q))) begin
      have_d = 1'b1;
      peak_d = val;
      idx_d  = idx;
    end
  end

  // Peak value, its lag index and the "seen a result" flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_q <= 1'b0;
      peak_q <= '0;
      idx_q  <= '0;
    end else begin
      have_q <= have_d;
      peak_q <= peak_d;
      idx_q  <= idx_d;
    end
  end

  assign best_idx = idx_q;

endmodule

// File: rtl/xcorr_seq_ctrl.sv
// Sequencer for the cross-correlation core: arms the core, forwards one frame
// of sample pairs, tracks the peak over the returned per-lag results and
// publishes the winning lag.
// Optional feature macro: XCORR_SEQ_TIMEOUT_EN adds a watchdog on the
// result-collection phase and drives the sticky tmo flag.
module xcorr_seq_ctrl
  import xcorr_pkg::*;
#(
  parameter int W       = 16,
  parameter int N_SAMP  = 512,
  parameter int MAX_LAG = 31,
  parameter int ACC_W   = 32,
  parameter int LAG_W   = 6,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    smp_valid,
  input  logic signed [W-1:0]     smp_x,
  input  logic signed [W-1:0]     smp_y,
  output logic                    xc_start,
  output logic signed [W-1:0]     xc_x,
  output logic signed [W-1:0]     xc_y,
  output logic                    xc_vld,
  input  logic                    xc_complete,
  input  logic signed [ACC_W-1:0] xc_result,
  output logic                    lag_valid,
  output logic signed [LAG_W-1:0] lag_diff,
  output logic                    busy,
  output logic                    ovr,
  output logic                    tmo
);

  localparam int SCNT_W = cnt_w(N_SAMP);

  xc_state_e               state_q, state_d;
  logic [SCNT_W-1:0]       scnt_q, scnt_d;
  logic signed [LAG_W-1:0] lag_idx_q, lag_idx_d;
  logic signed [W-1:0]     xc_x_q, xc_x_d, xc_y_q, xc_y_d;
  logic                    xc_vld_q, xc_vld_d;
  logic                    lag_valid_q, lag_valid_d;
  logic signed [LAG_W-1:0] lag_diff_q, lag_diff_d;
  logic                    ovr_q, ovr_d;
  logic                    pk_clr, pk_upd;
  logic signed [LAG_W-1:0] pk_idx;

`ifdef XCORR_SEQ_TIMEOUT_EN
  localparam int WDOG_W = cnt_w(TIMEOUT);
  logic [WDOG_W-1:0]       wdog_q, wdog_d;
  logic                    tmo_q, tmo_d;
`else
  logic                    unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  xcorr_peak_track #(
    .ACC_W (ACC_W),
    .LAG_W (LAG_W)
  ) u_peak (
    .clk      (clk),
    .rst      (rst),
    .clr      (pk_clr),
    .upd      (pk_upd),
    .val      (xc_result),
    .idx      (lag_idx_q),
    .best_idx (pk_idx)
  );

  // Next-state, datapath and sticky-flag logic; en low aborts any frame in flight.
  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    lag_idx_d   = lag_idx_q;
    xc_x_d      = '0;
    xc_y_d      = '0;
    xc_vld_d    = 1'b0;
    lag_valid_d = 1'b0;
    lag_diff_d  = lag_diff_q;
    ovr_d       = ovr_q;
    pk_clr      = 1'b0;
    pk_upd      = 1'b0;
`ifdef XCORR_SEQ_TIMEOUT_EN
    wdog_d      = wdog_q;
    tmo_d       = en ? tmo_q : 1'b0;
`endif

    if (!en) begin
      ovr_d = 1'b0;
    end else if (smp_valid && (state_q != STREAM)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (en) state_d = ARM;
      end
      ARM: begin
        scnt_d    = '0;
        lag_idx_d = LAG_W'(-MAX_LAG);
        pk_clr    = 1'b1;
        state_d   = en ? STREAM : IDLE;
      end
      STREAM: begin
        if (!en) begin
          state_d = IDLE;
        end else if (smp_valid) begin
          xc_x_d   = smp_x;
          xc_y_d   = smp_y;
          xc_vld_d = 1'b1;
          scnt_d   = scnt_q + SCNT_W'(1);
          if (scnt_q == SCNT_W'(N_SAMP - 1)) begin
            state_d = WAIT;
`ifdef XCORR_SEQ_TIMEOUT_EN
            wdog_d  = '0;
`endif
          end
        end
      end
      WAIT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (xc_complete) begin
          pk_upd    = 1'b1;
          lag_idx_d = lag_idx_q + LAG_W'(1);
`ifdef XCORR_SEQ_TIMEOUT_EN
          wdog_d    = '0;
`endif
          if (lag_idx_q == LAG_W'(MAX_LAG)) state_d = DONE;
        end
`ifdef XCORR_SEQ_TIMEOUT_EN
        else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
`endif
      end
      DONE: begin
        // Register the result and its strobe together so they line up.
        lag_diff_d  = pk_idx;
        lag_valid_d = 1'b1;
        state_d     = en ? ARM : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      scnt_q      <= '0;
      lag_idx_q   <= '0;
      xc_x_q      <= '0;
      xc_y_q      <= '0;
      xc_vld_q    <= 1'b0;
      lag_valid_q <= 1'b0;
      lag_diff_q  <= '0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      lag_idx_q   <= lag_idx_d;
      xc_x_q      <= xc_x_d;
      xc_y_q      <= xc_y_d;
      xc_vld_q    <= xc_vld_d;
      lag_valid_q <= lag_valid_d;
      lag_diff_q  <= lag_diff_d;
      ovr_q       <= ovr_d;
    end
  end

`ifdef XCORR_SEQ_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      tmo_q  <= tmo_d;
    end
  end
  assign tmo = tmo_q;
`else
  assign tmo = 1'b0;
`endif

  assign xc_start  = (state_q == ARM);
  assign busy      = (state_q != IDLE);
  assign xc_x      = xc_x_q;
  assign xc_y      = xc_y_q;
  assign xc_vld    = xc_vld_q;
  assign lag_valid = lag_valid_q;
  assign lag_diff  = lag_diff_q;
  assign ovr       = ovr_q;

endmodule
